// File: rtl/spicart_burst_if.sv
// ----------------------------------------------------------------------------
// spicart_burst_if
// Bundles the SPI byte-side and cart-side signals of the burst bridge.
//   spi_rx_data/valid/first : byte stream from the SPI slave (into the bridge)
//   spi_tx_data             : byte returned on the next SPI transfer
//   cart_a/din/wr/rd        : cart bus address, write data and 1-cycle strobes
//   cart_dout/cart_busy     : cart read data and back-pressure
//   bridge_busy             : FIFO non-empty, access outstanding or read pending
//   err_ovf/err_unf/err_clr : sticky error flags and their synchronous clear
// The bridge connects through the slave modport; its environment uses master.
// ----------------------------------------------------------------------------
interface spicart_burst_if #(
  parameter int AW = 16
);
  logic [7:0]    spi_rx_data;
  logic          spi_rx_valid;
  logic          spi_rx_first;
  logic [7:0]    spi_tx_data;
  logic [AW-1:0] cart_a;
  logic [7:0]    cart_din;
  logic [7:0]    cart_dout;
  logic          cart_wr;
  logic          cart_rd;
  logic          cart_busy;
  logic          bridge_busy;
  logic          err_ovf;
  logic          err_unf;
  logic          err_clr;

  modport slave (
    input  spi_rx_data, spi_rx_valid, spi_rx_first, cart_dout, cart_busy, err_clr,
    output spi_tx_data, cart_a, cart_din, cart_wr, cart_rd, bridge_busy, err_ovf, err_unf
  );

  modport master (
    output spi_rx_data, spi_rx_valid, spi_rx_first, cart_dout, cart_busy, err_clr,
    input  spi_tx_data, cart_a, cart_din, cart_wr, cart_rd, bridge_busy, err_ovf, err_unf
  );
endinterface

// File: rtl/spicart_burst.sv
// ----------------------------------------------------------------------------
// spicart_burst
// SPI-byte to cartridge bus bridge with burst reads/writes.
//   clk  : system clock
//   rst  : asynchronous active-high reset, discards any transaction in flight
//   bus  : spicart_burst_if.slave (SPI byte stream in, cart bus out, errors)
// A command byte (bit7 = write, bit6 = fixed address) is followed by
// ADDR_BYTES address bytes (MSB first), then data bytes. Writes are queued
// in a small FIFO so SPI bytes are absorbed while the cart is busy; reads are
// prefetched so the byte is ready for the following SPI transfer.
// ----------------------------------------------------------------------------
module spicart_burst #(
  parameter int AW         = 16,
  parameter int ADDR_BYTES = 2,
  parameter int WFIFO_LOG2 = 2
) (
  input logic           clk,
  input logic           rst,
  spicart_burst_if.slave bus
);

  localparam int DEPTH = 1 << WFIFO_LOG2;
  localparam int BCW   = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  typedef enum logic [1:0] {P_CMD, P_ADDR, P_DATA} pstate_e;
  typedef enum logic       {C_IDLE, C_WAIT}        cstate_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wentry_t;

  // Parser state
  pstate_e       pstate_q, pstate_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic          no_inc_q, no_inc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [AW+7:0] addr_shift;

  // Read request tracking: pending from post until captured; issued marks
  // that the outstanding cart_rd belongs to the current request.
  logic          rd_pend_q;
  logic          rd_issued_q;
  logic [AW-1:0] rd_addr_q;

  // Write FIFO
  wentry_t                fifo_mem [DEPTH];
  logic [WFIFO_LOG2-1:0]  wptr_q, rptr_q;
  logic [WFIFO_LOG2:0]    count_q;
  logic                   fifo_empty, fifo_full;

  // Cart side
  cstate_e       cstate_q;
  logic [AW-1:0] cart_a_q;
  logic [7:0]    cart_din_q;
  logic          cart_wr_q, cart_rd_q;
  logic [7:0]    tx_q;
  logic          err_ovf_q, err_unf_q;

  // Per-cycle events
  logic push, post, abort, set_ovf, set_unf;
  logic do_pop, do_rd, wait_done, do_capture;

  assign fifo_empty = (count_q == '0);
  // Count only reaches DEPTH when its MSB is set.
  assign fifo_full  = count_q[WFIFO_LOG2];

  assign do_pop     = (cstate_q == C_IDLE) && !fifo_empty && !bus.cart_busy;
  // Reads wait for the FIFO to drain so writes land first.
  assign do_rd      = (cstate_q == C_IDLE) && fifo_empty && rd_pend_q && !bus.cart_busy;
  assign wait_done  = (cstate_q == C_WAIT) && !bus.cart_busy;
  // A request posted or aborted this cycle makes the returning data stale.
  assign do_capture = wait_done && rd_issued_q && !post && !abort;

  assign addr_shift = {addr_q, bus.spi_rx_data};

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pstate_d = pstate_q;
    cmd_wr_d = cmd_wr_q;
    no_inc_d = no_inc_q;
    addr_d   = addr_q;
    bcnt_d   = bcnt_q;
    push     = 1'b0;
    post     = 1'b0;
    abort    = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;

    if (bus.spi_rx_valid) begin
      if (bus.spi_rx_first) begin
        abort    = 1'b1;
        cmd_wr_d = bus.spi_rx_data[7];
        no_inc_d = bus.spi_rx_data[6];
        addr_d   = '0;
        bcnt_d   = '0;
        pstate_d = P_ADDR;
      end else begin
        case (pstate_q)
          P_ADDR: begin
            addr_d = addr_shift[AW-1:0];
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == BCW'(ADDR_BYTES - 1)) begin
              pstate_d = P_DATA;
              post     = !cmd_wr_q;
            end
          end
          P_DATA: begin
            if (cmd_wr_q) begin
              if (fifo_full) set_ovf = 1'b1;
              else           push    = 1'b1;
            end else if (rd_pend_q) begin
              set_unf = 1'b1;
            end
            if (!no_inc_q) addr_d = addr_q + 1'b1;
            post = !cmd_wr_q;
          end
          default: ;  // no command yet: byte ignored
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate_q    <= P_CMD;
      cmd_wr_q    <= 1'b0;
      no_inc_q    <= 1'b0;
      addr_q      <= '0;
      bcnt_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_issued_q <= 1'b0;
      rd_addr_q   <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      cmd_wr_q <= cmd_wr_d;
      no_inc_q <= no_inc_d;
      addr_q   <= addr_d;
      bcnt_q   <= bcnt_d;

      if (push)   wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase

      if (abort) begin
        rd_pend_q   <= 1'b0;
        rd_issued_q <= 1'b0;
      end else if (post) begin
        rd_pend_q   <= 1'b1;
        rd_addr_q   <= addr_d;
        rd_issued_q <= 1'b0;
      end else if (do_rd) begin
        rd_issued_q <= 1'b1;
      end else if (do_capture) begin
        rd_pend_q   <= 1'b0;
        rd_issued_q <= 1'b0;
      end

      if (bus.err_clr)   err_ovf_q <= 1'b0;
      else if (set_ovf)  err_ovf_q <= 1'b1;
      if (bus.err_clr)   err_unf_q <= 1'b0;
      else if (set_unf)  err_unf_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy is governed by the pointers
  // and count, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= '{addr: addr_q, data: bus.spi_rx_data};
  end

  // Cart access FSM; strobes are decided on a cycle with cart_busy low and
  // appear registered on the next cycle. WAIT always lasts at least one cycle,
  // so write strobes are spaced by two or more cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cstate_q   <= C_IDLE;
      cart_a_q   <= '0;
      cart_din_q <= '0;
      cart_wr_q  <= 1'b0;
      cart_rd_q  <= 1'b0;
      tx_q       <= '0;
    end else begin
      cart_wr_q <= 1'b0;
      cart_rd_q <= 1'b0;
      case (cstate_q)
        C_IDLE: begin
          if (do_pop) begin
            cart_a_q   <= fifo_mem[rptr_q].addr;
            cart_din_q <= fifo_mem[rptr_q].data;
            cart_wr_q  <= 1'b1;
            cstate_q   <= C_WAIT;
          end else if (do_rd) begin
            cart_a_q  <= rd_addr_q;
            cart_rd_q <= 1'b1;
            cstate_q  <= C_WAIT;
          end
        end
        C_WAIT: begin
          if (wait_done) begin
            if (do_capture) tx_q <= bus.cart_dout;
            cstate_q <= C_IDLE;
          end
        end
        default: cstate_q <= C_IDLE;
      endcase
    end
  end

  assign bus.spi_tx_data = tx_q;
  assign bus.cart_a      = cart_a_q;
  assign bus.cart_din    = cart_din_q;
  assign bus.cart_wr     = cart_wr_q;
  assign bus.cart_rd     = cart_rd_q;
  assign bus.err_ovf     = err_ovf_q;
  assign bus.err_unf     = err_unf_q;
  assign bus.bridge_busy = !fifo_empty || (cstate_q == C_WAIT) || rd_pend_q;

endmodule
